quadrature_step_decoder: RTL and testbench

Front-end for the up/down binary counter. It turns two asynchronous quadrature encoder channels into a one-cycle `step` pulse and a `dir` level, which drive the counter's `en` and `up` inputs directly. The block synchronizes and glitch-filters both channels, decodes the Gray-code phase sequence at the selected resolution, and flags illegal double-bit transitions.

---
 rtl/quadrature_step_decoder.sv | 140 ++++++++++++++
 tb/tb_quadrature_step_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/quadrature_step_decoder.sv
// Quadrature encoder front-end: sync, glitch filter, Gray-code decode.
// Emits a one-cycle step plus direction, and a sticky illegal-move flag.
module quadrature_step_decoder #(
  parameter int FILTER_LEN = 4,
  parameter int RES        = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a_in,
  input  logic b_in,
  input  logic err_clr,
  output logic step,
  output logic dir,
  output logic err
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int SW = $clog2(FILTER_LEN + 4);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);
  localparam logic [SW-1:0] SET_END  = SW'(FILTER_LEN + 3);

  logic          a_s1_q, a_s1_d, a_s2_q, a_s2_d;
  logic          b_s1_q, b_s1_d, b_s2_q, b_s2_d;
  logic          fa_q, fa_d, fb_q, fb_d;
  logic [CW-1:0] ca_q, ca_d, cb_q, cb_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [1:0]    prev_q, prev_d;
  logic          step_q, step_d;
  logic          dir_q, dir_d;
  logic          err_q, err_d;

  logic          in_settle;
  logic [1:0]    phase;
  logic          fwd, rev, ill, a_tgl;
  logic          gf, gr;

  assign phase = {fa_q, fb_q};

  // Synchronizers, settle timer and per-channel mismatch filters.
  always_comb begin
    a_s1_d    = a_in;
    a_s2_d    = a_s1_q;
    b_s1_d    = b_in;
    b_s2_d    = b_s1_q;
    in_settle = (settle_q != SET_END);
    settle_d  = settle_q;
    fa_d      = fa_q;
    fb_d      = fb_q;
    ca_d      = '0;
    cb_d      = '0;
    if (in_settle) begin
      settle_d = settle_q + SW'(1);
      fa_d     = a_s2_q;
      fb_d     = b_s2_q;
    end else begin
      if (a_s2_q != fa_q) begin
        if (ca_q == CNT_LAST) fa_d = a_s2_q;
        else ca_d = ca_q + CW'(1);
      end
      if (b_s2_q != fb_q) begin
        if (cb_q == CNT_LAST) fb_d = b_s2_q;
        else cb_d = cb_q + CW'(1);
      end
    end
  end

  // Phase-transition classification and resolution gating.
  always_comb begin
    fwd   = (prev_q == 2'b00 && phase == 2'b10) ||
            (prev_q == 2'b10 && phase == 2'b11) ||
            (prev_q == 2'b11 && phase == 2'b01) ||
            (prev_q == 2'b01 && phase == 2'b00);
    rev   = (prev_q == 2'b10 && phase == 2'b00) ||
            (prev_q == 2'b11 && phase == 2'b10) ||
            (prev_q == 2'b01 && phase == 2'b11) ||
            (prev_q == 2'b00 && phase == 2'b01);
    ill   = ((prev_q ^ phase) == 2'b11);
    a_tgl = prev_q[1] ^ phase[1];
    gf    = 1'b0;
    gr    = 1'b0;
    if (RES == 1) begin
      gf = fwd && (phase == 2'b00);
      gr = rev && (prev_q == 2'b00);
    end else if (RES == 2) begin
      gf = fwd && a_tgl;
      gr = rev && a_tgl;
    end else begin
      gf = fwd;
      gr = rev;
    end
    gf     = gf && !in_settle;
    gr     = gr && !in_settle;
    prev_d = phase;
    step_d = gf || gr;
    dir_d  = dir_q;
    if (gf) dir_d = 1'b1;
    if (gr) dir_d = 1'b0;
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (ill && !in_settle) err_d = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_s1_q   <= 1'b0;
      a_s2_q   <= 1'b0;
      b_s1_q   <= 1'b0;
      b_s2_q   <= 1'b0;
      fa_q     <= 1'b0;
      fb_q     <= 1'b0;
      ca_q     <= '0;
      cb_q     <= '0;
      settle_q <= '0;
      prev_q   <= 2'b00;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      a_s1_q   <= a_s1_d;
      a_s2_q   <= a_s2_d;
      b_s1_q   <= b_s1_d;
      b_s2_q   <= b_s2_d;
      fa_q     <= fa_d;
      fb_q     <= fb_d;
      ca_q     <= ca_d;
      cb_q     <= cb_d;
      settle_q <= settle_d;
      prev_q   <= prev_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
    end
  end

  assign step = step_q;
  assign dir  = dir_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Scoreboard bench for quadrature_step_decoder at x4, x2 and x1.
// Directed phase vectors carry hand-computed step/dir expectations.
module tb_quadrature_step_decoder;

  localparam int FL = 4;
  localparam int LAT = FL + 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic a_in = 1'b1;
  logic b_in = 1'b1;
  logic err_clr = 1'b0;
  logic step4, dir4, err4;
  logic step2, dir2, err2;
  logic step1, dir1, err1;

  quadrature_step_decoder #(.FILTER_LEN(FL), .RES(4)) u4 (
    .clk(clk), .reset_n(reset_n), .a_in(a_in), .b_in(b_in),
    .err_clr(err_clr), .step(step4), .dir(dir4), .err(err4)
  );
  quadrature_step_decoder #(.FILTER_LEN(FL), .RES(2)) u2 (
    .clk(clk), .reset_n(reset_n), .a_in(a_in), .b_in(b_in),
    .err_clr(err_clr), .step(step2), .dir(dir2), .err(err2)
  );
  quadrature_step_decoder #(.FILTER_LEN(FL), .RES(1)) u1 (
    .clk(clk), .reset_n(reset_n), .a_in(a_in), .b_in(b_in),
    .err_clr(err_clr), .step(step1), .dir(dir1), .err(err1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic d;
    int   c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  logic st_prev [3];
  int nvec = 0;
  int nmis = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, want, cyc);
    end
  endtask

  task automatic mon(int id, logic st, logic dr);
    exp_t e;
    int   n;
    if (st === 1'b1) begin
      n = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
      if (n == 0) begin
        chk($sformatf("unexpected_step_u%0d", id), {31'd0, st}, 0);
      end else begin
        if (id == 0) e = q0.pop_front();
        else if (id == 1) e = q1.pop_front();
        else e = q2.pop_front();
        chk($sformatf("dir_u%0d", id), {31'd0, dr}, {31'd0, e.d});
        chk($sformatf("step_cycle_u%0d", id), cyc, e.c);
        chk($sformatf("step_width_u%0d", id), {31'd0, st_prev[id]}, 0);
      end
    end
    st_prev[id] = st;
  endtask

  // Monitor: pops the scoreboard whenever a step pulse is seen.
  always @(negedge clk) begin
    mon(0, step4, dir4);
    mon(1, step2, dir2);
    mon(2, step1, dir1);
  end

  task automatic push(int id, logic d, int c);
    exp_t e;
    e.d = d;
    e.c = c;
    if (id == 0) q0.push_back(e);
    else if (id == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  // Caller is at a negedge; drive, schedule expectations, hold.
  task automatic apply(logic a, logic b, int hold,
                       logic s4, logic s2, logic s1, logic d);
    a_in = a;
    b_in = b;
    if (s4) push(0, d, cyc + LAT);
    if (s2) push(1, d, cyc + LAT);
    if (s1) push(2, d, cyc + LAT);
    repeat (hold) @(negedge clk);
  endtask

  task automatic chk_err(string nm, logic want);
    chk({nm, "_u4"}, {31'd0, err4}, {31'd0, want});
    chk({nm, "_u2"}, {31'd0, err2}, {31'd0, want});
    chk({nm, "_u1"}, {31'd0, err1}, {31'd0, want});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    st_prev[0] = 1'b0;
    st_prev[1] = 1'b0;
    st_prev[2] = 1'b0;
    #1;
    chk("rst_step", {29'd0, step4, step2, step1}, 0);
    chk("rst_dir", {29'd0, dir4, dir2, dir1}, 0);
    chk_err("rst_err", 1'b0);

    // Rest at 11 through reset release: no step, no err.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk_err("settle_err", 1'b0);

    // 11 -> 01 -> 00 forward, then a full forward cycle.
    apply(1'b0, 1'b1, 20, 1, 1, 0, 1'b1);
    apply(1'b0, 1'b0, 20, 1, 0, 1, 1'b1);
    apply(1'b1, 1'b0, 20, 1, 1, 0, 1'b1);
    apply(1'b1, 1'b1, 20, 1, 0, 0, 1'b1);
    apply(1'b0, 1'b1, 20, 1, 1, 0, 1'b1);
    apply(1'b0, 1'b0, 20, 1, 0, 1, 1'b1);

    // Full reverse cycle.
    apply(1'b0, 1'b1, 20, 1, 0, 1, 1'b0);
    apply(1'b1, 1'b1, 20, 1, 1, 0, 1'b0);
    apply(1'b1, 1'b0, 20, 1, 0, 0, 1'b0);
    apply(1'b0, 1'b0, 20, 1, 1, 0, 1'b0);
    chk_err("legal_err", 1'b0);

    // Glitches: 3-cycle pulse rejected, 4-cycle pulse accepted.
    apply(1'b1, 1'b0, 3, 0, 0, 0, 1'b0);
    apply(1'b0, 1'b0, 20, 0, 0, 0, 1'b0);
    apply(1'b1, 1'b0, 4, 1, 1, 0, 1'b1);
    apply(1'b0, 1'b0, 20, 1, 1, 0, 1'b0);

    // Illegal 00 -> 11: err sets and sticks.
    apply(1'b1, 1'b1, 20, 0, 0, 0, 1'b0);
    chk_err("ill_err", 1'b1);
    repeat (50) @(negedge clk);
    chk_err("ill_hold", 1'b1);

    // Clear.
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk_err("clr_err", 1'b0);

    // Illegal 11 -> 00 coincident with err_clr: set wins.
    c = cyc;
    apply(1'b0, 1'b0, LAT - 1, 0, 0, 0, 1'b0);
    chk_err("pre_set", 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("set_cycle", cyc, c + LAT);
    chk_err("set_wins", 1'b1);
    repeat (20) @(negedge clk);

    // Reset asserted during a step pulse.
    apply(1'b1, 1'b0, LAT, 1, 1, 0, 1'b1);
    chk("mid_step", {31'd0, step4}, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_step", {29'd0, step4, step2, step1}, 0);
    chk("mid_rst_dir", {29'd0, dir4, dir2, dir1}, 0);
    chk_err("mid_rst_err", 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk_err("post_rst_err", 1'b0);
    chk("post_rst_dir", {29'd0, dir4, dir2, dir1}, 0);

    chk("q_u4_empty", q0.size(), 0);
    chk("q_u2_empty", q1.size(), 0);
    chk("q_u1_empty", q2.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
